// File: rtl/div_pkg.sv
// Shared widths, FSM state type and constants for the sequential 8-by-4 divider.
package div_pkg;

  localparam int DVD_W = 8;          // dividend / quotient width
  localparam int DVS_W = 4;          // divisor / remainder width
  localparam int PR_W  = DVS_W + 1;  // partial remainder carries one guard bit
  localparam int CNT_W = 3;          // counts the 8 restoring steps

  // Quotient reported when the divisor is zero (all ones, like a saturated result).
  localparam logic [DVD_W-1:0] DZ_QUOT = 8'hFF;

  // Counter value of the final restoring step.
  localparam logic [CNT_W-1:0] LAST_STEP = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits. Purely combinational so it
// can be chained for an unrolled divider as well as iterated.
module div_step
  import div_pkg::*;
(
  input  logic [PR_W-1:0]  i_pr,       // partial remainder before the shift
  input  logic             i_dvd_bit,  // next dividend bit, MSB first
  input  logic [DVS_W-1:0] i_divisor,
  output logic [PR_W-1:0]  o_pr,       // partial remainder after the step
  output logic             o_qbit      // quotient bit produced by this step
);

  logic [PR_W-1:0] w_trial;
  logic [PR_W-1:0] w_dvs_ext;
  logic            w_fits;

  // Trial subtraction; a set guard bit in the incoming remainder means the
  // shifted value already exceeds any 4-bit divisor.
  always_comb begin
    w_trial   = {i_pr[DVS_W-1:0], i_dvd_bit};
    w_dvs_ext = {1'b0, i_divisor};
    w_fits    = i_pr[PR_W-1] || (w_trial >= w_dvs_ext);
    if (w_fits) begin
      o_pr   = w_trial - w_dvs_ext;
      o_qbit = 1'b1;
    end else begin
      o_pr   = w_trial;
      o_qbit = 1'b0;
    end
  end

endmodule

// File: rtl/divide_8by4_seq.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient
// bit per clock, behind valid/ready request and result ports. A zero divisor
// yields quotient 0xFF, remainder = low nibble of the dividend and a flag.
module divide_8by4_seq
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero
);

  state_t           r_state;
  logic [DVD_W-1:0] r_q_sr;     // dividend bits shift out, quotient bits shift in
  logic [DVS_W-1:0] r_d;        // latched divisor
  logic [PR_W-1:0]  r_pr;       // partial remainder
  logic [CNT_W-1:0] r_cnt;      // step counter
  logic             r_dz;       // latched divisor == 0
  logic [DVS_W-1:0] r_dvd_lo;   // dividend low nibble, reported on divide by zero
  logic             r_out_valid;
  logic [DVD_W-1:0] r_quot;
  logic [DVS_W-1:0] r_rem;
  logic             r_dz_out;

  logic [PR_W-1:0]  w_pr_next;
  logic             w_qbit;
  logic [DVD_W-1:0] w_q_next;

  div_step u_step (
    .i_pr      (r_pr),
    .i_dvd_bit (r_q_sr[DVD_W-1]),
    .i_divisor (r_d),
    .o_pr      (w_pr_next),
    .o_qbit    (w_qbit)
  );

  assign w_q_next = {r_q_sr[DVD_W-2:0], w_qbit};

  // Ready is a pure state decode, held low while reset is asserted.
  assign in_ready    = (r_state == IDLE) && !rst;
  assign out_valid   = r_out_valid;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dz_out;

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_q_sr      <= '0;
      r_d         <= '0;
      r_pr        <= '0;
      r_cnt       <= '0;
      r_dz        <= 1'b0;
      r_dvd_lo    <= '0;
      r_out_valid <= 1'b0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_dz_out    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_q_sr   <= dividend;
            r_d      <= divisor;
            r_pr     <= '0;
            r_cnt    <= '0;
            r_dz     <= (divisor == 4'd0);
            r_dvd_lo <= dividend[DVS_W-1:0];
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_pr   <= w_pr_next;
          r_q_sr <= w_q_next;
          r_cnt  <= r_cnt + 3'd1;
          if (r_cnt == LAST_STEP) begin
            // Final step: publish the result straight from the step outputs.
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_quot      <= r_dz ? DZ_QUOT : w_q_next;
            r_rem       <= r_dz ? r_dvd_lo : w_pr_next[DVS_W-1:0];
            r_dz_out    <= r_dz;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divide_8by4_seq.sv
// Scoreboard bench for divide_8by4_seq: the driver pushes expected results
// computed with plain arithmetic, an independent monitor pops and compares.
module tb_divide_8by4_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  typedef struct {
    int q;
    int r;
    int dz;
    int acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = 0;
  bit   prev_valid = 1'b0;
  bit   rand_ready = 1'b0;

  divide_8by4_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, data on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) chk("unexpected_valid", 1, 0);
        // negedge before the accept edge -> negedge after the 8th step edge
        else chk("latency", cyc - sb[0].acc_cyc, 9);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = sb.pop_front();
          chk("quotient", int'(quotient), e.q);
          chk("remainder", int'(remainder), e.r);
          chk("div_by_zero", int'(div_by_zero), e.dz);
        end
      end
    end
    prev_valid = out_valid;
  end

  // Random consumer backpressure during the random phase.
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic issue(input int dvd, input int dvs, input int eq, input int er, input int edz);
    int tries = 0;
    @(negedge clk);
    in_valid = 1'b1;
    dividend = dvd[7:0];
    divisor  = dvs[3:0];
    while (!in_ready && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    last_acc = cyc;
    sb.push_back('{eq, er, edz, cyc});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int a;
    int b;
    int prev_acc;
    int t;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = 8'd0;
    divisor   = 4'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dz", int'(div_by_zero), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);

    // Directed cases
    issue(200, 7, 28, 4, 0);
    drain();
    issue(255, 1, 255, 0, 0);
    issue(5, 9, 0, 5, 0);
    drain();
    issue(37, 0, 255, 5, 1);
    drain();
    issue(13 * 11, 11, 13, 0, 0);
    drain();

    // Round trip over every multiplier product with a nonzero B; back-to-back
    // requests also pin down the 10-cycle throughput.
    prev_acc = -1;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 1; ib < 16; ib++) begin
        issue(ia * ib, ib, ia, 0, 0);
        if (prev_acc >= 0) chk("throughput", last_acc - prev_acc, 10);
        prev_acc = last_acc;
      end
    end
    drain();

    // Backpressure: result must hold, request side must stay closed.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(100, 3, 33, 1, 0);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_quotient", int'(quotient), 33);
      chk("bp_remainder", int'(remainder), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    repeat (3) @(negedge clk);
    chk("bp_no_extra", int'(out_valid), 0);

    // Reset in the middle of a calculation discards the pending result.
    issue(200, 7, 28, 4, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready_low", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_quotient", int'(quotient), 0);
    chk("midrst_remainder", int'(remainder), 0);
    chk("midrst_dz", int'(div_by_zero), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    issue(9, 2, 4, 1, 0);
    drain();

    // Random operands against the arithmetic model, with random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 150; n++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 15);
      if (b == 0) issue(a, b, 255, a % 16, 1);
      else        issue(a, b, a / b, a % b, 0);
    end
    drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
